// File: rtl/branch_pkg.sv
// Shared types and constants for the ID-stage branch controller.
// Branch class decode is centralised here so the top and evaluator agree.
package branch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    LT     = 2'd1,
    CBZ    = 2'd2,
    UNCOND = 2'd3
  } br_class_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Unconditional wins over the conditional class bits.
  function automatic br_class_t decode_class(input logic uncond,
                                             input logic br_taken,
                                             input logic br_zero);
    br_class_t cls;
    cls = NONE;
    if (uncond)
      cls = UNCOND;
    else if (br_taken)
      cls = br_zero ? CBZ : LT;
    return cls;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Pure combinational taken/not-taken evaluation for one decoded branch class.
module branch_cond_eval
  import branch_pkg::*;
(
  input  br_class_t  br_class,
  input  logic [3:0] flags,
  input  logic       reg_zero,
  output logic       taken
);

  // Z and C are carried for completeness but no supported branch reads them.
  logic unused_zc;
  assign unused_zc = flags[FLAG_Z] ^ flags[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (br_class)
      LT:      taken = flags[FLAG_N] ^ flags[FLAG_V];
      CBZ:     taken = reg_zero;
      UNCOND:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: NZCV register with EX forwarding, CBZ operand
// stall FSM, optional wrong-path flush, saturating taken counter, hold timeout.
//
// state | meaning
// RUN   | normal issue, no stall in progress
// HOLD  | CBZ waiting on its operand; hcnt counts stall cycles
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DELAY_SLOT = 1,
  parameter int MAX_HOLD   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             UncondBr,
  input  logic             brTaken,
  input  logic             brZero,
  input  logic             id_regZero,
  input  logic             id_operandPending,
  input  logic             ex_valid,
  input  logic             ex_setFlags,
  input  logic             ex_negative,
  input  logic             ex_overflow,
  input  logic             ex_carry_out,
  input  logic             ex_zero,
  output logic             TakeBranch,
  output logic             FlushIFID,
  output logic             StallFront,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] takenCount,
  output logic             holdErr
);

  localparam int HCNT_W = ($clog2(MAX_HOLD + 1) < 2) ? 2 : $clog2(MAX_HOLD + 1);
  localparam logic [HCNT_W-1:0] HOLD_LIMIT = HCNT_W'(MAX_HOLD);

  state_t            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q;
  logic [3:0]        flags_q;
  logic [3:0]        ex_nzcv;
  logic [3:0]        eff_flags;
  logic [CNT_W-1:0]  count_q;
  logic              herr_q;
  logic              ex_write;
  logic              cond_taken;
  logic              stall;
  logic              take;
  br_class_t         br_class;

  always_comb begin
    ex_nzcv         = 4'b0000;
    ex_nzcv[FLAG_N] = ex_negative;
    ex_nzcv[FLAG_Z] = ex_zero;
    ex_nzcv[FLAG_C] = ex_carry_out;
    ex_nzcv[FLAG_V] = ex_overflow;
  end

  assign ex_write  = ex_valid & ex_setFlags;
  assign eff_flags = ex_write ? ex_nzcv : flags_q;
  assign br_class  = id_valid ? decode_class(UncondBr, brTaken, brZero) : NONE;

  branch_cond_eval u_cond_eval (
    .br_class (br_class),
    .flags    (eff_flags),
    .reg_zero (id_regZero),
    .taken    (cond_taken)
  );

  // Decisions are suppressed while reset is held so a stall drops at once.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    take    = 1'b0;
    if (!reset) begin
      stall = (br_class == CBZ) && id_operandPending;
      take  = cond_taken && !stall;
    end
    case (state_q)
      RUN:     if (stall)  state_d = HOLD;
      HOLD:    if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // hcnt holds the number of stall cycles already completed for this CBZ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      herr_q <= 1'b0;
    end else begin
      if (stall) begin
        if (hcnt_q != {HCNT_W{1'b1}})
          hcnt_q <= hcnt_q + 1'b1;
      end else begin
        hcnt_q <= '0;
      end
      if ((state_q == HOLD) && stall && (hcnt_q >= HOLD_LIMIT))
        herr_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= 4'b0000;
    else if (ex_write)
      flags_q <= ex_nzcv;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (take && !stall && (count_q != {CNT_W{1'b1}}))
      count_q <= count_q + 1'b1;
  end

  assign TakeBranch = take;
  assign FlushIFID  = (DELAY_SLOT == 0) ? take : 1'b0;
  assign StallFront = stall;
  assign flags      = flags_q;
  assign takenCount = count_q;
  assign holdErr    = herr_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with a queue-based scoreboard.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0, UncondBr = 1'b0, brTaken = 1'b0, brZero = 1'b0;
  logic       id_regZero = 1'b0, id_operandPending = 1'b0;
  logic       ex_valid = 1'b0, ex_setFlags = 1'b0;
  logic       ex_negative = 1'b0, ex_overflow = 1'b0, ex_carry_out = 1'b0, ex_zero = 1'b0;
  logic       TakeBranch, FlushIFID, StallFront, holdErr;
  logic [3:0] flags;
  logic [3:0] takenCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [2:0] tfs;
    logic [3:0] fl;
    logic [3:0] cnt;
    logic       herr;
  } exp_t;

  exp_t exp_q[$];

  branch_ctrl #(.CNT_W(4), .DELAY_SLOT(0), .MAX_HOLD(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .id_valid          (id_valid),
    .UncondBr          (UncondBr),
    .brTaken           (brTaken),
    .brZero            (brZero),
    .id_regZero        (id_regZero),
    .id_operandPending (id_operandPending),
    .ex_valid          (ex_valid),
    .ex_setFlags       (ex_setFlags),
    .ex_negative       (ex_negative),
    .ex_overflow       (ex_overflow),
    .ex_carry_out      (ex_carry_out),
    .ex_zero           (ex_zero),
    .TakeBranch        (TakeBranch),
    .FlushIFID         (FlushIFID),
    .StallFront        (StallFront),
    .flags             (flags),
    .takenCount        (takenCount),
    .holdErr           (holdErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %b expected %b", nm, field, got, want);
    end
  endtask

  // Monitor: every negedge with a pending expectation compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "take",  {3'b000, TakeBranch}, {3'b000, e.tfs[2]});
        chk(e.nm, "flush", {3'b000, FlushIFID},  {3'b000, e.tfs[1]});
        chk(e.nm, "stall", {3'b000, StallFront}, {3'b000, e.tfs[0]});
        chk(e.nm, "flags", flags, e.fl);
        chk(e.nm, "count", takenCount, e.cnt);
        chk(e.nm, "herr",  {3'b000, holdErr}, {3'b000, e.herr});
      end
    end
  end

  // in = {reset, id_valid, UncondBr, brTaken, brZero, id_regZero, pending, ex_valid, ex_setFlags, NZCV}
  // tfs = {TakeBranch, FlushIFID, StallFront}; fl/cnt/herr are register values visible this cycle
  task automatic step(input string nm, input logic [12:0] in, input logic [2:0] tfs,
                      input logic [3:0] fl, input logic [3:0] cnt, input logic herr);
    exp_t e;
    @(posedge clk);
    #1;
    {reset, id_valid, UncondBr, brTaken, brZero, id_regZero, id_operandPending,
     ex_valid, ex_setFlags, ex_negative, ex_zero, ex_carry_out, ex_overflow} = in;
    e.nm = nm; e.tfs = tfs; e.fl = fl; e.cnt = cnt; e.herr = herr;
    exp_q.push_back(e);
  endtask

  localparam logic [12:0] IDLE    = 13'b0_0000_00_00_0000;
  localparam logic [12:0] UNC     = 13'b0_1100_00_00_0000;
  localparam logic [12:0] CBZ_P   = 13'b0_1011_01_00_0000;
  localparam logic [12:0] CBZ_Z   = 13'b0_1011_10_00_0000;
  localparam logic [12:0] CBZ_NZ  = 13'b0_1011_00_00_0000;

  initial begin
    step("reset",     13'b1_0000_00_00_0000, 3'b000, 4'b0000, 4'd0, 1'b0);
    step("uncond",    UNC,                   3'b110, 4'b0000, 4'd0, 1'b0);
    step("cnt_one",   IDLE,                  3'b000, 4'b0000, 4'd1, 1'b0);
    step("blt_fwd",   13'b0_1010_00_11_1000, 3'b110, 4'b0000, 4'd1, 1'b0);
    step("flag_reg",  IDLE,                  3'b000, 4'b1000, 4'd2, 1'b0);
    step("blt_nv",    13'b0_1010_00_11_1001, 3'b000, 4'b1000, 4'd2, 1'b0);
    step("blt_nowr",  13'b0_1010_00_10_1000, 3'b000, 4'b1001, 4'd2, 1'b0);
    step("blt_noval", 13'b0_1010_00_01_1000, 3'b000, 4'b1001, 4'd2, 1'b0);
    step("wr_v",      13'b0_0000_00_11_0001, 3'b000, 4'b1001, 4'd2, 1'b0);
    step("blt_reg",   13'b0_1010_00_00_0000, 3'b110, 4'b0001, 4'd2, 1'b0);
    step("cbz_p1",    CBZ_P,                 3'b001, 4'b0001, 4'd3, 1'b0);
    step("cbz_p2",    CBZ_P,                 3'b001, 4'b0001, 4'd3, 1'b0);
    step("cbz_res",   CBZ_Z,                 3'b110, 4'b0001, 4'd3, 1'b0);
    step("cbz_cnt",   IDLE,                  3'b000, 4'b0001, 4'd4, 1'b0);
    step("cbz_nt",    CBZ_NZ,                3'b000, 4'b0001, 4'd4, 1'b0);
    step("cls_01",    13'b0_1001_10_00_0000, 3'b000, 4'b0001, 4'd4, 1'b0);
    step("no_valid",  13'b0_0100_00_00_0000, 3'b000, 4'b0001, 4'd4, 1'b0);
    step("hold1",     CBZ_P,                 3'b001, 4'b0001, 4'd4, 1'b0);
    step("hold2",     CBZ_P,                 3'b001, 4'b0001, 4'd4, 1'b0);
    step("hold3",     CBZ_P,                 3'b001, 4'b0001, 4'd4, 1'b0);
    step("hold4",     CBZ_P,                 3'b001, 4'b0001, 4'd4, 1'b0);
    step("hold_done", CBZ_NZ,                3'b000, 4'b0001, 4'd4, 1'b1);
    step("herr_stky", IDLE,                  3'b000, 4'b0001, 4'd4, 1'b1);
    step("exit_p",    CBZ_P,                 3'b001, 4'b0001, 4'd4, 1'b1);
    step("exit_inv",  13'b0_0011_01_00_0000, 3'b000, 4'b0001, 4'd4, 1'b1);
    step("exit_idle", IDLE,                  3'b000, 4'b0001, 4'd4, 1'b1);
    step("rst_hold",  CBZ_P,                 3'b001, 4'b0001, 4'd4, 1'b1);
    step("rst_mid",   13'b1_1011_01_00_0000, 3'b000, 4'b0000, 4'd0, 1'b0);
    step("post_rst",  CBZ_P,                 3'b001, 4'b0000, 4'd0, 1'b0);
    step("post_res",  CBZ_Z,                 3'b110, 4'b0000, 4'd0, 1'b0);
    step("sat_rst",   13'b1_0000_00_00_0000, 3'b000, 4'b0000, 4'd0, 1'b0);
    // Odd entries also raise CBZ-pending bits, which UncondBr must override.
    for (int i = 0; i < 17; i++)
      step($sformatf("sat%0d", i), (i % 2 == 1) ? 13'b0_1111_01_00_0000 : UNC,
           3'b110, 4'b0000, (i < 15) ? 4'(i) : 4'd15, 1'b0);
    step("sat_end",   IDLE,                  3'b000, 4'b0000, 4'd15, 1'b0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
